axi_stream_fifo_drain: RTL and testbench
========================================

AXI_STREAM_FIFO_DRAIN -- requirements
Module: axi_stream_fifo_drain

Interface
REQ-001 SHALL have parameter width, default 8: data bits per beat.
REQ-002 SHALL have parameter pkt_len, default 4: beats per packet; legal range 1..256.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port enable  input  1  when 1, the block may pop the FIFO; when 0, no new pops occur, and the buffered beats still drain.
REQ-006 SHALL have port fifo_empty  input  1  empty flag from the upstream FIFO.
REQ-007 SHALL have port fifo_read_data  input  width  show-ahead head-of-FIFO data, valid whenever fifo_empty=0.
REQ-008 SHALL have port fifo_pop  output  1  one-cycle pop strobe to the FIFO.
REQ-009 SHALL have port m_tvalid  output  1  AXI-Stream master valid.
REQ-010 SHALL have port m_tready  input  1  AXI-Stream slave ready.
REQ-011 SHALL have port m_tdata  output  width  AXI-Stream data.
REQ-012 SHALL have port m_tlast  output  1  last beat of a packet.
REQ-013 SHALL have port occupancy  output  2  number of beats held internally, 0..2.

Function
REQ-014 SHALL hold beats in a 2-entry buffer: a head register driving m_tdata and a skid register, with occupancy counter occ.
REQ-015 SHALL drive fifo_pop = rst & enable & ~fifo_empty & (occ < 2); fifo_pop SHALL have no combinational dependence on m_tready.
REQ-016 SHALL capture fifo_read_data into the buffer on the same edge at which fifo_pop=1.
REQ-017 SHALL drive m_tvalid = (occ != 0) from registered state only.
REQ-018 SHALL define a handshake as m_tvalid & m_tready on a rising edge; on a handshake, the skid entry (if occ=2) SHALL move to the head.
REQ-019 SHALL update occ as occ + pop - handshake on each edge; a simultaneous pop and handshake SHALL leave occ unchanged and the data order intact.
REQ-020 SHALL hold m_tdata stable while m_tvalid=1 and m_tready=0, and SHALL never deassert m_tvalid without a handshake.
REQ-021 SHALL sustain one beat per cycle when the FIFO is non-empty, enable=1, and m_tready=1 continuously (steady state occ=1).
REQ-022 SHALL have a latency of 1 cycle: data popped at edge N SHALL appear on m_tdata with m_tvalid=1 after edge N.
REQ-023 SHALL count beats with beat_cnt over 0..pkt_len-1, incrementing on each handshake and wrapping to 0 after pkt_len-1.
REQ-024 SHALL drive m_tlast = m_tvalid & (beat_cnt == pkt_len-1); with pkt_len=1, m_tlast SHALL be 1 on every valid beat.
REQ-025 SHALL not change beat_cnt when enable is toggled; enable SHALL affect only pops.
REQ-026 SHALL drive occupancy = occ.
REQ-027 SHALL treat fifo_read_data as don't-care when fifo_empty=1; it SHALL never be captured in that case.

Reset
REQ-028 SHALL, on any edge with rst=0, set occ=0 and beat_cnt=0 and discard buffered beats; data registers need not be reset.
REQ-029 SHALL hold outputs during and after reset at fifo_pop=0, m_tvalid=0, m_tlast=0, and occupancy=0.
REQ-030 SHALL, on a reset asserted mid-packet, restart the next packet at beat 0, and SHALL not pop the FIFO while rst=0.

Verification
REQ-031 SHALL cover the following case: pkt_len=4; FIFO holds 0x10..0x17; m_tready=1 and enable=1 constantly -> 8 consecutive beats 0x10..0x17 starting 1 cycle after the first pop, with m_tlast on 0x13 and 0x17.
REQ-032 SHALL cover the following case: FIFO holds 0xA1, 0xA2, 0xA3; m_tready=0 for 5 cycles, then 1 -> exactly 2 pops, occupancy=2, m_tdata=0xA1 stable; after release, output order is 0xA1, 0xA2, 0xA3 with no loss or duplication.
REQ-033 SHALL cover the following case: random m_tready (50%) and random FIFO refill over 1000 beats -> the output stream equals the input order, and m_tlast occurs every 4th handshake.
REQ-034 SHALL cover the following case: occ=2 with enable dropped to 0 -> fifo_pop stays 0, and exactly 2 more beats are delivered, after which m_tvalid=0.
REQ-035 SHALL cover the following case: rst=0 pulsed after beat 2 of a packet with occ=2 -> next edge gives m_tvalid=0 and occupancy=0; the next delivered beat has beat_cnt=0, so m_tlast falls on the 4th beat after reset.
REQ-036 SHALL cover the following case: pkt_len=1, 3 beats -> m_tlast=1 on every beat.

Source files
------------

// File: rtl/axi_stream_fifo_drain.sv
// Drains a show-ahead FIFO into an AXI-Stream master through a 2-entry head/skid buffer, framing pkt_len-beat packets.
// Latency: 1 cycle from the pop edge to m_tvalid/m_tdata; one beat per cycle in steady state.
// Backpressure: pops only while occupancy < 2, so fifo_pop never depends combinationally on m_tready.
module axi_stream_fifo_drain #(
    parameter int width   = 8,
    parameter int pkt_len = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [width-1:0] fifo_read_data,
    output logic             fifo_pop,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [width-1:0] m_tdata,
    output logic             m_tlast,
    output logic [1:0]       occupancy
);

    localparam int cnt_w = (pkt_len > 1) ? $clog2(pkt_len) : 1;
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(pkt_len - 1);

    logic [1:0]       occ;
    logic [width-1:0] head_dat;
    logic [width-1:0] skid_dat;
    logic [cnt_w-1:0] beat_cnt;
    logic             pop;
    logic             hs;

    assign pop       = rst & enable & ~fifo_empty & (occ < 2'd2);
    assign hs        = m_tvalid & m_tready;
    assign fifo_pop  = pop;
    assign m_tvalid  = (occ != 2'd0);
    assign m_tdata   = head_dat;
    assign m_tlast   = m_tvalid & (beat_cnt == last_cnt);
    assign occupancy = occ;

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ      <= 2'd0;
            beat_cnt <= '0;
        end else begin
            occ <= occ + 2'(pop) - 2'(hs);
            if (hs) begin
                beat_cnt <= (beat_cnt == last_cnt) ? '0 : beat_cnt + cnt_w'(1);
            end
        end
    end

    // A pop lands in the head when the head is (or is about to become) free, otherwise in the skid.
    always_ff @(posedge clk) begin
        if (pop && (occ == 2'd0 || (occ == 2'd1 && hs))) begin
            head_dat <= fifo_read_data;
        end else if (hs && occ == 2'd2) begin
            head_dat <= skid_dat;
        end
        if (pop && occ == 2'd1 && !hs) begin
            skid_dat <= fifo_read_data;
        end
    end

endmodule

// File: tb/tb_axi_stream_fifo_drain.sv
// Randomized bench for axi_stream_fifo_drain against a queue-based model of the FIFO and the in-flight beats.
module tb_axi_stream_fifo_drain;
    localparam int W   = 8;
    localparam int PKT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         fifo_empty;
    logic [W-1:0] fifo_read_data;
    logic         m_tready;
    logic         fifo_pop, m_tvalid, m_tlast;
    logic [W-1:0] m_tdata;
    logic [1:0]   occupancy;
    logic         p1_pop, p1_tvalid, p1_tlast;
    logic [W-1:0] p1_tdata;
    logic [1:0]   p1_occupancy;

    int checks    = 0;
    int failures  = 0;
    int hs_since_rst = 0;
    int hs_total  = 0;
    int pops_total = 0;
    logic [W-1:0] src_q[$];
    logic [W-1:0] infl_q[$];

    axi_stream_fifo_drain #(.width(W), .pkt_len(PKT)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_read_data(fifo_read_data), .fifo_pop(fifo_pop), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast), .occupancy(occupancy)
    );

    axi_stream_fifo_drain #(.width(W), .pkt_len(1)) dut_p1 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_read_data(fifo_read_data), .fifo_pop(p1_pop), .m_tvalid(p1_tvalid),
        .m_tready(m_tready), .m_tdata(p1_tdata), .m_tlast(p1_tlast), .occupancy(p1_occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // One clock: present FIFO head, check outputs at negedge, then advance the model at posedge.
    task automatic tick();
        logic exp_pop, exp_vld, did_hs;
        fifo_empty     = (src_q.size() == 0);
        fifo_read_data = fifo_empty ? W'($urandom) : src_q[0];
        @(negedge clk);
        exp_pop = rst && enable && (src_q.size() != 0) && (infl_q.size() < 2);
        exp_vld = (infl_q.size() != 0);
        chk("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
        chk("m_tvalid", 32'(m_tvalid), 32'(exp_vld));
        chk("occupancy", 32'(occupancy), infl_q.size());
        chk("p1_pop", 32'(p1_pop), 32'(exp_pop));
        chk("p1_tlast", 32'(p1_tlast), 32'(exp_vld));
        if (exp_vld) begin
            chk("m_tdata", 32'(m_tdata), 32'(infl_q[0]));
            chk("m_tlast", 32'(m_tlast), 32'((hs_since_rst % PKT) == PKT - 1));
            chk("p1_tdata", 32'(p1_tdata), 32'(infl_q[0]));
        end else begin
            chk("m_tlast_idle", 32'(m_tlast), 32'(0));
        end
        did_hs = exp_vld && m_tready;
        @(posedge clk);
        if (!rst) begin
            infl_q.delete();
            hs_since_rst = 0;
        end else begin
            if (did_hs) begin
                void'(infl_q.pop_front());
                hs_since_rst++;
                hs_total++;
            end
            if (exp_pop) begin
                infl_q.push_back(src_q.pop_front());
                pops_total++;
            end
        end
        #1;
    endtask

    initial begin
        int h0, p0, cyc;
        rst = 1'b0; enable = 1'b1; m_tready = 1'b1;
        fifo_empty = 1'b1; fifo_read_data = '0;
        src_q.push_back(8'h55);
        src_q.push_back(8'h66);
        repeat (3) tick();
        chk("rst_occ", 32'(occupancy), 32'(0));
        chk("rst_pop", 32'(fifo_pop), 32'(0));
        src_q.delete();
        rst = 1'b1;
        tick();

        // Continuous streaming of 8 beats, two packets.
        h0 = hs_total;
        for (int i = 0; i < 8; i++) src_q.push_back(W'(8'h10 + i));
        repeat (10) tick();
        chk("s1_beats", hs_total - h0, 8);

        // Stall: two pops fill the buffer, head held stable.
        m_tready = 1'b0;
        p0 = pops_total;
        src_q.push_back(8'hA1); src_q.push_back(8'hA2); src_q.push_back(8'hA3);
        repeat (5) tick();
        chk("s2_pops", pops_total - p0, 2);
        chk("s2_occ", 32'(occupancy), 32'(2));
        chk("s2_head", 32'(m_tdata), 32'(8'hA1));
        m_tready = 1'b1;
        repeat (5) tick();
        chk("s2_idle", 32'(m_tvalid), 32'(0));

        // Enable drop with a full buffer: exactly the two buffered beats drain.
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) src_q.push_back(W'(8'hB0 + i));
        repeat (3) tick();
        chk("s4_full", 32'(occupancy), 32'(2));
        enable = 1'b0; m_tready = 1'b1;
        h0 = hs_total;
        repeat (4) tick();
        chk("s4_beats", hs_total - h0, 2);
        chk("s4_valid", 32'(m_tvalid), 32'(0));
        chk("s4_pop", 32'(fifo_pop), 32'(0));
        enable = 1'b1;
        repeat (4) tick();

        // Reset mid-packet with a full buffer.
        rst = 1'b0; tick(); rst = 1'b1;
        for (int i = 0; i < 10; i++) src_q.push_back(W'(8'hC0 + i));
        m_tready = 1'b1;
        for (int g = 0; g < 20 && hs_since_rst < 2; g++) begin
            m_tready = (hs_since_rst < 2);
            tick();
        end
        chk("s5_two_beats", hs_since_rst, 2);
        m_tready = 1'b0;
        for (int g = 0; g < 10 && infl_q.size() < 2; g++) tick();
        chk("s5_pre_occ", 32'(occupancy), 32'(2));
        rst = 1'b0; tick();
        chk("s5_rst_vld", 32'(m_tvalid), 32'(0));
        chk("s5_rst_occ", 32'(occupancy), 32'(0));
        rst = 1'b1; m_tready = 1'b1;
        repeat (12) tick();

        // Random ready, enable and refill over 1000 beats.
        h0 = hs_total;
        cyc = 0;
        while (hs_total - h0 < 1000 && cyc < 20000) begin
            m_tready = 1'($urandom_range(0, 1));
            enable   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1 && src_q.size() < 6) src_q.push_back(W'($urandom));
            tick();
            cyc++;
        end
        chk("s6_beats", 32'(hs_total - h0 >= 1000), 32'(1));

        enable = 1'b1; m_tready = 1'b1;
        for (int g = 0; g < 50 && (src_q.size() != 0 || infl_q.size() != 0); g++) tick();
        tick();
        chk("end_idle", 32'(m_tvalid), 32'(0));
        chk("end_occ", 32'(occupancy), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
